// File: rtl/spi_burst_sequencer_pkg.sv
// Shared definitions for the SPI burst sequencer:
// one-hot FSM encoding, byte width and a small helper.
package spi_pkg;

    localparam int BYTE_W = 8;

    localparam int IDLE_B  = 0;
    localparam int LEAD_B  = 1;
    localparam int ISSUE_B = 2;
    localparam int WAIT_B  = 3;
    localparam int LAG_B   = 4;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_LEAD  = 5'b00010,
        S_ISSUE = 5'b00100,
        S_WAIT  = 5'b01000,
        S_LAG   = 5'b10000
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_burst_sequencer_fifo.sv
// Synchronous first-word-fall-through FIFO; a read on a full FIFO
// frees its slot in the same cycle so a simultaneous write lands.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rd_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd && !empty;
    assign do_wr   = wr && (!full || do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/spi_burst_sequencer.sv
// Multi-byte SPI transaction front-end: TX/RX FIFOs, byte issue
// handshake toward spi_controller and chip-select lead/lag timing.
module spi_burst_sequencer
    import spi_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = 8,
    parameter int CS_LEAD    = 2,
    parameter int CS_LAG     = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [BYTE_W-1:0] i_tx_data,
    input  logic              i_tx_wr,
    output logic              o_tx_full,
    output logic [BYTE_W-1:0] o_rx_data,
    input  logic              i_rx_rd,
    output logic              o_rx_empty,
    output logic              o_rx_overflow,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_cs_n,
    output logic [BYTE_W-1:0] o_spi_tx,
    output logic              o_spi_tx_valid,
    input  logic              i_spi_ready,
    input  logic [BYTE_W-1:0] i_spi_rx,
    input  logic              i_spi_rx_valid
);

    localparam int CS_MAX = max_int(CS_LEAD, CS_LAG);
    localparam int TW     = $clog2(CS_MAX) + 1;

    localparam logic [TW-1:0] LEAD_LAST = TW'(CS_LEAD - 1);
    localparam logic [TW-1:0] LAG_LAST  = TW'(CS_LAG - 1);

    state_t            state;
    state_t            state_d;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  cnt_d;
    logic [TW-1:0]     timer;
    logic [TW-1:0]     timer_d;

    logic              tx_empty;
    logic              tx_pop;
    logic [BYTE_W-1:0] tx_head;
    logic              rx_full;
    logic              rx_push;

    logic [BYTE_W-1:0] spi_tx_d;
    logic              spi_tx_valid_d;
    logic              ovf_clr;
    logic              done_d;
    logic              cs_n_d;

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr      (i_tx_wr && !o_tx_full),
        .wr_data (i_tx_data),
        .rd      (tx_pop),
        .full    (o_tx_full),
        .empty   (tx_empty),
        .rd_data (tx_head)
    );

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .wr      (rx_push),
        .wr_data (i_spi_rx),
        .rd      (i_rx_rd),
        .full    (rx_full),
        .empty   (o_rx_empty),
        .rd_data (o_rx_data)
    );

    assign o_busy = (state != S_IDLE);

    always_comb begin
        state_d        = state;
        cnt_d          = cnt;
        timer_d        = timer;
        tx_pop         = 1'b0;
        spi_tx_valid_d = 1'b0;
        spi_tx_d       = o_spi_tx;
        rx_push        = 1'b0;
        ovf_clr        = 1'b0;

        unique case (1'b1)
            state[IDLE_B]: begin
                if (i_start && (i_len != '0)) begin
                    state_d = S_LEAD;
                    cnt_d   = i_len;
                    timer_d = '0;
                    ovf_clr = 1'b1;
                end
            end
            state[LEAD_B]: begin
                if (timer == LEAD_LAST) begin
                    state_d = S_ISSUE;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            state[ISSUE_B]: begin
                // An empty TX FIFO simply stalls here with CS held low.
                if (!tx_empty && i_spi_ready) begin
                    tx_pop         = 1'b1;
                    spi_tx_valid_d = 1'b1;
                    spi_tx_d       = tx_head;
                    state_d        = S_WAIT;
                end
            end
            state[WAIT_B]: begin
                if (i_spi_rx_valid) begin
                    rx_push = 1'b1;
                    cnt_d   = cnt - 1'b1;
                    if (cnt == LEN_W'(1)) begin
                        state_d = S_LAG;
                        timer_d = '0;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            state[LAG_B]: begin
                if (timer == LAG_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered CS/done rise together in the final LAG cycle.
        done_d = (state_d == S_LAG) && (timer_d == LAG_LAST);
        cs_n_d = (state_d == S_IDLE) || done_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            timer          <= '0;
            o_cs_n         <= 1'b1;
            o_done         <= 1'b0;
            o_spi_tx       <= '0;
            o_spi_tx_valid <= 1'b0;
            o_rx_overflow  <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            timer          <= timer_d;
            o_cs_n         <= cs_n_d;
            o_done         <= done_d;
            o_spi_tx       <= spi_tx_d;
            o_spi_tx_valid <= spi_tx_valid_d;
            if (ovf_clr) begin
                o_rx_overflow <= 1'b0;
            end else if (rx_push && rx_full && !i_rx_rd) begin
                o_rx_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Randomized bench for spi_burst_sequencer with an echoing controller
// model and queue-based TX/RX reference.
module tb_spi_burst_sequencer;

    localparam int DEPTH = 4;
    localparam int LEN_W = 8;
    localparam int LEAD  = 2;
    localparam int LAG   = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic [7:0]       tx_data = '0;
    logic             tx_wr = 1'b0;
    logic             rx_rd = 1'b0;
    logic             spi_ready = 1'b1;
    logic [7:0]       spi_rx = '0;
    logic             spi_rx_valid = 1'b0;

    logic       o_tx_full;
    logic [7:0] o_rx_data;
    logic       o_rx_empty;
    logic       o_rx_overflow;
    logic       o_busy;
    logic       o_done;
    logic       o_cs_n;
    logic [7:0] o_spi_tx;
    logic       o_spi_tx_valid;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] issued[$];
    int         iss_rd = 0;
    logic [7:0] tx_model[$];

    int   strobe_cnt = 0;
    int   done_cnt = 0;
    int   cs_viol = 0;
    int   last_rx_cyc = 0;
    int   done_cyc = 0;
    int   cs_fall_cyc = 0;
    int   first_strobe_cyc = 0;
    bit   first_pending = 1'b0;
    logic prev_cs = 1'b1;

    spi_burst_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .LEN_W      (LEN_W),
        .CS_LEAD    (LEAD),
        .CS_LAG     (LAG)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_len          (len),
        .i_tx_data      (tx_data),
        .i_tx_wr        (tx_wr),
        .o_tx_full      (o_tx_full),
        .o_rx_data      (o_rx_data),
        .i_rx_rd        (rx_rd),
        .o_rx_empty     (o_rx_empty),
        .o_rx_overflow  (o_rx_overflow),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_cs_n         (o_cs_n),
        .o_spi_tx       (o_spi_tx),
        .o_spi_tx_valid (o_spi_tx_valid),
        .i_spi_ready    (spi_ready),
        .i_spi_rx       (spi_rx),
        .i_spi_rx_valid (spi_rx_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change just after a falling edge, so an rx_valid seen
    // here was sampled by the DUT at the end of the previous cycle.
    always @(negedge clk) begin
        prev_cs <= o_cs_n;
        if (!rst) begin
            if (o_spi_tx_valid) begin
                strobe_cnt <= strobe_cnt + 1;
                if (first_pending) begin
                    first_strobe_cyc <= cyc;
                    first_pending    <= 1'b0;
                end
            end
            if (prev_cs && !o_cs_n) begin
                cs_fall_cyc   <= cyc;
                first_pending <= 1'b1;
            end
            if (o_done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (spi_rx_valid) last_rx_cyc <= cyc - 1;
            if ((o_busy && o_cs_n && !o_done) || (!o_busy && !o_cs_n))
                cs_viol <= cs_viol + 1;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Controller model: accepts one byte, answers its complement later.
    initial begin
        logic [7:0] b;
        forever begin
            tick();
            if (o_spi_tx_valid) begin
                b = o_spi_tx;
                issued.push_back(b);
                spi_ready = 1'b0;
                repeat ($urandom_range(0, 3)) tick();
                spi_rx = ~b;
                spi_rx_valid = 1'b1;
                tick();
                spi_rx_valid = 1'b0;
                spi_ready = 1'b1;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1);
    end

    task automatic write_tx(input logic [7:0] b, output bit ok);
        int w = 0;
        while (o_tx_full && w < 300) begin
            tick();
            w++;
        end
        ok = !o_tx_full;
        if (ok) begin
            tx_data = b;
            tx_wr = 1'b1;
            tx_model.push_back(b);
            tick();
            tx_wr = 1'b0;
        end
    endtask

    task automatic start_txn(input int n);
        start = 1'b1;
        len = LEN_W'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit to);
        int w = 0;
        while (done_cnt == d0 && w < 2000) begin
            tick();
            w++;
        end
        to = (done_cnt == d0);
        tick();
    endtask

    task automatic pop_rx(output logic [7:0] b);
        b = o_rx_data;
        rx_rd = 1'b1;
        tick();
        rx_rd = 1'b0;
    endtask

    task automatic next_issued(output logic [7:0] b, output bit have);
        have = (iss_rd < issued.size());
        b = have ? issued[iss_rd] : 8'h00;
        if (have) iss_rd++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({o_cs_n, o_rx_empty, o_busy, o_done, o_spi_tx_valid} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_ctl: got cs_n,rx_empty,busy,done,valid=%b want 11000",
                     {o_cs_n, o_rx_empty, o_busy, o_done, o_spi_tx_valid});
        end
        checks++;
        if ({o_tx_full, o_rx_overflow, o_spi_tx} !== 10'h000) begin
            errors++;
            $display("FAIL reset_misc: got full=%b ovf=%b tx=%h want 0 0 00",
                     o_tx_full, o_rx_overflow, o_spi_tx);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] exp_tx[$];
        logic [7:0] got;
        logic [7:0] b;
        bit have, ok, to;
        int d0 = done_cnt;
        int s0 = strobe_cnt;
        int v0 = cs_viol;
        int bad = 0;
        write_tx(8'hA5, ok); if (!ok) bad++;
        write_tx(8'h3C, ok); if (!ok) bad++;
        write_tx(8'hFF, ok); if (!ok) bad++;
        start_txn(3);
        wait_done(d0, to);
        checks++;
        if (to || bad != 0) begin
            errors++;
            $display("FAIL basic_timeout: timeout=%0d bad_writes=%0d want 0 0", to, bad);
        end
        checks++;
        if (strobe_cnt - s0 !== 3) begin
            errors++;
            $display("FAIL basic_strobes: got %0d want 3", strobe_cnt - s0);
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL basic_done: got %0d pulses want 1", done_cnt - d0);
        end
        for (int i = 0; i < 3; i++) begin
            b = tx_model.pop_front();
            exp_tx.push_back(b);
            next_issued(got, have);
            checks++;
            if (!have || got !== b) begin
                errors++;
                $display("FAIL basic_issue%0d: got %h want %h", i, got, b);
            end
        end
        checks++;
        if (done_cyc - last_rx_cyc !== LAG) begin
            errors++;
            $display("FAIL basic_lag: got %0d cycles want %0d", done_cyc - last_rx_cyc, LAG);
        end
        checks++;
        if (first_strobe_cyc - cs_fall_cyc !== LEAD + 1) begin
            errors++;
            $display("FAIL basic_lead: got %0d cycles want %0d",
                     first_strobe_cyc - cs_fall_cyc, LEAD + 1);
        end
        checks++;
        if (cs_viol !== v0) begin
            errors++;
            $display("FAIL basic_cs: got %0d cs glitches want 0", cs_viol - v0);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o_rx_empty !== 1'b0 || o_rx_data !== ~exp_tx[i]) begin
                errors++;
                $display("FAIL basic_rx%0d: got %h empty=%b want %h", i, o_rx_data, o_rx_empty, ~exp_tx[i]);
            end
            pop_rx(got);
        end
        checks++;
        if (o_rx_empty !== 1'b1 || o_rx_overflow !== 1'b0) begin
            errors++;
            $display("FAIL basic_rx_end: got empty=%b ovf=%b want 1 0", o_rx_empty, o_rx_overflow);
        end
    endtask

    task automatic test_underrun();
        logic [7:0] b0 = 8'($urandom);
        logic [7:0] b1 = 8'($urandom);
        logic [7:0] got;
        bit have, ok0, ok1, to;
        int d0 = done_cnt;
        int s0 = strobe_cnt;
        int v0 = cs_viol;
        write_tx(b0, ok0);
        start_txn(2);
        repeat (100) tick();
        checks++;
        if (strobe_cnt - s0 !== 1 || o_cs_n !== 1'b0 || o_busy !== 1'b1 || done_cnt !== d0) begin
            errors++;
            $display("FAIL underrun_stall: got strobes=%0d cs_n=%b busy=%b done=%0d want 1 0 1 0",
                     strobe_cnt - s0, o_cs_n, o_busy, done_cnt - d0);
        end
        write_tx(b1, ok1);
        wait_done(d0, to);
        checks++;
        if (to || !ok0 || !ok1 || strobe_cnt - s0 !== 2) begin
            errors++;
            $display("FAIL underrun_finish: got timeout=%0d strobes=%0d want 0 2", to, strobe_cnt - s0);
        end
        for (int i = 0; i < 2; i++) begin
            logic [7:0] e = tx_model.pop_front();
            next_issued(got, have);
            checks++;
            if (!have || got !== e) begin
                errors++;
                $display("FAIL underrun_issue%0d: got %h want %h", i, got, e);
            end
            checks++;
            if (o_rx_data !== ~e || o_rx_empty !== 1'b0) begin
                errors++;
                $display("FAIL underrun_rx%0d: got %h want %h", i, o_rx_data, ~e);
            end
            pop_rx(got);
        end
        checks++;
        if (cs_viol !== v0) begin
            errors++;
            $display("FAIL underrun_cs: got %0d cs glitches want 0", cs_viol - v0);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_tx[$];
        logic [7:0] got;
        bit have, ok, to;
        int d0 = done_cnt;
        int s0 = strobe_cnt;
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            write_tx(8'($urandom), ok);
            if (!ok) bad++;
        end
        checks++;
        if (o_tx_full !== 1'b1) begin
            errors++;
            $display("FAIL ovf_txfull: got %b want 1", o_tx_full);
        end
        // Write while full must be dropped; the model does not queue it.
        tx_data = 8'($urandom);
        tx_wr = 1'b1;
        tick();
        tx_wr = 1'b0;
        start_txn(6);
        for (int i = 0; i < 2; i++) begin
            write_tx(8'($urandom), ok);
            if (!ok) bad++;
        end
        wait_done(d0, to);
        checks++;
        if (to || bad != 0 || strobe_cnt - s0 !== 6 || done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL ovf_txn: got timeout=%0d bad=%0d strobes=%0d done=%0d want 0 0 6 1",
                     to, bad, strobe_cnt - s0, done_cnt - d0);
        end
        for (int i = 0; i < 6; i++) begin
            logic [7:0] e = tx_model.pop_front();
            exp_tx.push_back(e);
            next_issued(got, have);
            checks++;
            if (!have || got !== e) begin
                errors++;
                $display("FAIL ovf_issue%0d: got %h want %h", i, got, e);
            end
        end
        checks++;
        if (o_rx_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: got %b want 1", o_rx_overflow);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (o_rx_empty !== 1'b0 || o_rx_data !== ~exp_tx[i]) begin
                errors++;
                $display("FAIL ovf_rx%0d: got %h empty=%b want %h", i, o_rx_data, o_rx_empty, ~exp_tx[i]);
            end
            pop_rx(got);
        end
        checks++;
        if (o_rx_empty !== 1'b1) begin
            errors++;
            $display("FAIL ovf_rx_empty: got %b want 1", o_rx_empty);
        end
        d0 = done_cnt;
        write_tx(8'($urandom), ok);
        start_txn(1);
        checks++;
        if (o_rx_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b want 0", o_rx_overflow);
        end
        wait_done(d0, to);
        begin
            logic [7:0] e = tx_model.pop_front();
            next_issued(got, have);
            checks++;
            if (to || !have || got !== e || o_rx_data !== ~e) begin
                errors++;
                $display("FAIL ovf_next: got issue=%h rx=%h timeout=%0d want %h %h 0", got, o_rx_data, to, e, ~e);
            end
            pop_rx(got);
        end
    endtask

    task automatic test_abort();
        logic [7:0] got;
        logic [7:0] x = 8'($urandom);
        bit have, ok, to;
        int d0 = done_cnt;
        int s0 = strobe_cnt;
        int w = 0;
        for (int i = 0; i < 3; i++) write_tx(8'($urandom), ok);
        start_txn(3);
        while (strobe_cnt - s0 < 2 && w < 500) begin
            tick();
            w++;
        end
        checks++;
        if (strobe_cnt - s0 !== 2) begin
            errors++;
            $display("FAIL abort_reach: got %0d strobes want 2", strobe_cnt - s0);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({o_cs_n, o_busy, o_rx_empty, o_tx_full, o_spi_tx_valid} !== 5'b10100) begin
            errors++;
            $display("FAIL abort_state: got cs_n,busy,rx_empty,full,valid=%b want 10100",
                     {o_cs_n, o_busy, o_rx_empty, o_tx_full, o_spi_tx_valid});
        end
        rst = 1'b0;
        w = 0;
        while ((!spi_ready || spi_rx_valid) && w < 20) begin
            tick();
            w++;
        end
        repeat (4) tick();
        checks++;
        if (done_cnt !== d0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_nodone: got done=%0d busy=%b want 0 0", done_cnt - d0, o_busy);
        end
        for (int i = 0; i < 2; i++) begin
            logic [7:0] e = tx_model.pop_front();
            next_issued(got, have);
            checks++;
            if (!have || got !== e) begin
                errors++;
                $display("FAIL abort_issue%0d: got %h want %h", i, got, e);
            end
        end
        tx_model.delete();
        s0 = strobe_cnt;
        d0 = done_cnt;
        start_txn(1);
        repeat (10) tick();
        checks++;
        if (strobe_cnt !== s0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_txempty: got strobes=%0d busy=%b want 0 1", strobe_cnt - s0, o_busy);
        end
        write_tx(x, ok);
        wait_done(d0, to);
        next_issued(got, have);
        checks++;
        if (to || !have || got !== x || o_rx_data !== ~x) begin
            errors++;
            $display("FAIL abort_after: got issue=%h rx=%h timeout=%0d want %h %h 0", got, o_rx_data, to, x, ~x);
        end
        void'(tx_model.pop_front());
        pop_rx(got);
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        bit have, ok, to;
        int d0 = done_cnt;
        int w = 0;
        bit idle_bad = 1'b0;
        write_tx(8'($urandom), ok);
        write_tx(8'($urandom), ok);
        start_txn(1);
        while (done_cnt == d0 && w < 500) begin
            tick();
            w++;
        end
        start = 1'b1;
        len = LEN_W'(1);
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_cs_n !== 1'b1 || done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL b2b_ignore: got busy=%b cs_n=%b done=%0d want 0 1 1", o_busy, o_cs_n, done_cnt - d0);
        end
        tick();
        start = 1'b0;
        checks++;
        if (o_busy !== 1'b1 || o_cs_n !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart: got busy=%b cs_n=%b want 1 0", o_busy, o_cs_n);
        end
        wait_done(d0 + 1, to);
        for (int i = 0; i < 2; i++) begin
            logic [7:0] e = tx_model.pop_front();
            next_issued(got, have);
            checks++;
            if (to || !have || got !== e || o_rx_data !== ~e) begin
                errors++;
                $display("FAIL b2b_byte%0d: got issue=%h rx=%h want %h %h", i, got, o_rx_data, e, ~e);
            end
            pop_rx(got);
        end
        start_txn(0);
        repeat (5) begin
            if (o_busy !== 1'b0 || o_cs_n !== 1'b1) idle_bad = 1'b1;
            tick();
        end
        checks++;
        if (idle_bad) begin
            errors++;
            $display("FAIL b2b_len0: got busy/cs activity want busy=0 cs_n=1");
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [7:0] exp_tx[$];
            logic [7:0] got;
            bit have, ok, to;
            int n = $urandom_range(1, 7);
            int need = (n > tx_model.size()) ? n - tx_model.size() : 0;
            int extra = (tx_model.size() == 0) ? $urandom_range(0, 1) : 0;
            int total = need + extra;
            int room = DEPTH - tx_model.size();
            int pre = $urandom_range(0, (total < room) ? total : room);
            int d0 = done_cnt;
            int s0 = strobe_cnt;
            int bad = 0;
            for (int i = 0; i < pre; i++) begin
                write_tx(8'($urandom), ok);
                if (!ok) bad++;
            end
            start_txn(n);
            for (int i = pre; i < total; i++) begin
                write_tx(8'($urandom), ok);
                if (!ok) bad++;
            end
            wait_done(d0, to);
            checks++;
            if (to || bad != 0 || strobe_cnt - s0 !== n || done_cnt - d0 !== 1) begin
                errors++;
                $display("FAIL rand%0d_txn: got timeout=%0d bad=%0d strobes=%0d done=%0d want 0 0 %0d 1",
                         it, to, bad, strobe_cnt - s0, done_cnt - d0, n);
            end
            for (int i = 0; i < n; i++) begin
                logic [7:0] e = tx_model.pop_front();
                exp_tx.push_back(e);
                next_issued(got, have);
                checks++;
                if (!have || got !== e) begin
                    errors++;
                    $display("FAIL rand%0d_issue%0d: got %h want %h", it, i, got, e);
                end
            end
            checks++;
            if (o_rx_overflow !== (n > DEPTH)) begin
                errors++;
                $display("FAIL rand%0d_ovf: got %b want %b", it, o_rx_overflow, n > DEPTH);
            end
            for (int i = 0; i < ((n < DEPTH) ? n : DEPTH); i++) begin
                checks++;
                if (o_rx_empty !== 1'b0 || o_rx_data !== ~exp_tx[i]) begin
                    errors++;
                    $display("FAIL rand%0d_rx%0d: got %h want %h", it, i, o_rx_data, ~exp_tx[i]);
                end
                pop_rx(got);
            end
            checks++;
            if (o_rx_empty !== 1'b1) begin
                errors++;
                $display("FAIL rand%0d_rx_empty: got %b want 1", it, o_rx_empty);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_overflow();
        test_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
